// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES-128 decrypt, one round per clock, on-the-fly round keys.
// Optional rk10 cache, enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_dec_iter #(
  parameter int NR   = 10,
  parameter int RK_W = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RK_W-1:0] key,
  input  logic [RK_W-1:0] data_in,
  input  logic            valid_in,
  output logic            ready,
  output logic [RK_W-1:0] data_out,
  output logic            valid_out
);

  typedef logic [127:0] blk_t;
  typedef enum logic [1:0] {IDLE, KEXP, DEC} st_e;

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rc(input logic [3:0] i);
    logic [7:0] v;
    v = 8'h00;
    unique case (i)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // SubWord(RotWord(w))
  function automatic logic [31:0] srw(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic blk_t kfwd(input blk_t k, input logic [7:0] c);
    logic [31:0] a, b, cc, d;
    a  = k[127:96] ^ srw(k[31:0]) ^ {c, 24'h0};
    b  = k[95:64] ^ a;
    cc = k[63:32] ^ b;
    d  = k[31:0] ^ cc;
    return {a, b, cc, d};
  endfunction

  function automatic blk_t kinv(input blk_t k, input logic [7:0] c);
    logic [31:0] a, b, cc, d;
    d  = k[63:32] ^ k[31:0];
    cc = k[95:64] ^ k[63:32];
    b  = k[127:96] ^ k[95:64];
    a  = k[127:96] ^ srw(d) ^ {c, 24'h0};
    return {a, b, cc, d};
  endfunction

  function automatic blk_t isr_isb(input blk_t s);
    blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = ISBOX[s[127-8*(r+4*((c-r)&3)) -: 8]];
    return o;
  endfunction

  function automatic blk_t imc(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
      o[119-32*c -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
      o[111-32*c -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
      o[103-32*c -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
    end
    return o;
  endfunction

  st_e        r_state;
  logic [3:0] r_cnt;
  logic       r_ready;
  logic       r_vout;
  blk_t       r_dout;
  blk_t       r_rk;
  blk_t       r_ct;
  blk_t       r_st;
`ifdef AES_DEC_KEY_CACHE_EN
  blk_t       r_tag;
  blk_t       r_crk;
  logic       r_cval;
`endif

  blk_t w_fwd;
  blk_t w_rkd;
  blk_t w_t;
  blk_t w_imc;

  assign w_fwd = kfwd(r_rk, rc(r_cnt));
  assign w_rkd = kinv(r_rk, rc(r_cnt + 4'd1));
  assign w_t   = isr_isb(r_st) ^ w_rkd;
  assign w_imc = imc(w_t);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_vout  <= 1'b0;
      r_dout  <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      r_cval  <= 1'b0;
`endif
    end else begin
      r_vout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_ready <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            if (r_cval && key == r_tag) begin
              r_rk    <= r_crk;
              r_st    <= data_in ^ r_crk;
              r_cnt   <= LAST - 4'd1;
              r_state <= DEC;
            end else begin
              r_tag   <= key;
              r_cval  <= 1'b0;
              r_rk    <= key;
              r_ct    <= data_in;
              r_cnt   <= 4'd1;
              r_state <= KEXP;
            end
`else
            r_rk    <= key;
            r_ct    <= data_in;
            r_cnt   <= 4'd1;
            r_state <= KEXP;
`endif
          end
        end
        KEXP: begin
          r_rk <= w_fwd;
          if (r_cnt == LAST) begin
            r_st    <= r_ct ^ w_fwd;
            r_cnt   <= LAST - 4'd1;
            r_state <= DEC;
`ifdef AES_DEC_KEY_CACHE_EN
            r_crk   <= w_fwd;
            r_cval  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DEC: begin
          r_rk <= w_rkd;
          if (r_cnt == 4'd0) begin
            r_dout  <= w_t;
            r_vout  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_st  <= w_imc;
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign valid_out = r_vout;
  assign data_out  = r_dout;

endmodule

// File: tb/tb_aes_dec_iter.sv
// tb_aes_dec_iter: random loopback against a byte-level AES-128 encrypt model,
// FIPS vectors, back-to-back, mid-run reset and (optionally) key-cache latency.
module tb_aes_dec_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] data_in = '0;
  logic         valid_in = 1'b0;
  logic         ready;
  logic [127:0] data_out;
  logic         valid_out;

  aes_dec_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready     (ready),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0]   sb [256];
  logic [127:0] m_tag = '0;
  bit           m_val = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int x, y, p;
    x = int'(a);
    y = int'(b);
    p = 0;
    while (y != 0) begin
      if (y % 2 == 1) p = p ^ x;
      x = x * 2;
      if (x >= 256) x = x ^ 'h11b;
      y = y / 2;
    end
    return 8'(p);
  endfunction

  // S-box from the definition: multiplicative inverse by search, then affine map
  task automatic build_sbox();
    logic [7:0] inv, s, cc;
    cc = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
               ^ inv[(i+7)%8] ^ cc[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rcon, a0, a1, a2, a3;
    logic [31:0]  x;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int n = 0; n < 16; n++)
      s[n] = p[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row+4*col] = t[row+4*((col+row)%4)];
      if (r < 10)
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3;
          s[4*col+1] = a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3;
          s[4*col+2] = a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03);
          s[4*col+3] = gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02);
        end
      for (int n = 0; n < 16; n++)
        s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
    end
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  function automatic int lat_of(input logic [127:0] k);
    return (CACHE && m_val && k == m_tag) ? 10 : 20;
  endfunction

  task automatic note_done(input logic [127:0] k, input int lat);
    if (lat == 20) begin
      m_tag = k;
      m_val = 1'b1;
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) chk("ready_wait", {127'h0, ready}, 128'h1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] k,
                           input logic [127:0] ct, input logic [127:0] pt,
                           input bit tog);
    int el, n, lo;
    bit got;
    el = lat_of(k);
    wait_ready();
    key = k;
    data_in = ct;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    lo = ready ? 0 : 1;
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      if (tog) begin
        valid_in = 1'($urandom_range(0, 1));
        key = {$urandom, $urandom, $urandom, $urandom};
        data_in = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk);
      #1;
      n++;
      if (valid_out) got = 1'b1;
      else if (!ready) lo++;
    end
    valid_in = 1'b0;
    chk({tag, "_lat"}, 128'(n), 128'(el));
    chk({tag, "_pt"}, data_out, pt);
    chk({tag, "_rdy_lo"}, 128'(lo), 128'(el));
    chk({tag, "_rdy_out"}, {127'h0, ready}, 128'h1);
    note_done(k, el);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {127'h0, valid_out}, 128'h0);
  endtask

  initial begin
    int n, lo, l1, l2, pulses;
    bit got;
    logic [127:0] rk, rp;
    build_sbox();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", {127'h0, ready}, 128'h1);
    chk("rst_vout", {127'h0, valid_out}, 128'h0);
    chk("rst_dout", data_out, 128'h0);

    run_block("fips_c1", K1, C1, P1, 1'b0);
    run_block("fips_b", K2, C2, P2, 1'b0);

    // back-to-back with valid_in held high
    l1 = lat_of(K1);
    wait_ready();
    key = K1;
    data_in = C1;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    key = K2;
    data_in = C2;
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      got = valid_out;
    end
    chk("b2b_lat1", 128'(n), 128'(l1));
    chk("b2b_pt1", data_out, P1);
    note_done(K1, l1);
    l2 = lat_of(K2);
    n = 0;
    lo = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      valid_in = 1'b0;
      got = valid_out;
      if (!got && !ready) lo++;
    end
    chk("b2b_gap", 128'(n), 128'(l2 + 1));
    chk("b2b_pt2", data_out, P2);
    chk("b2b_rdy_lo", 128'(lo), 128'(l2));
    note_done(K2, l2);

    // reset asserted at edge E5 of a request
    wait_ready();
    key = K1;
    data_in = C1;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_vout", {127'h0, valid_out}, 128'h0);
    chk("abort_dout", data_out, 128'h0);
    rst_n = 1'b1;
    m_val = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready", {127'h0, ready}, 128'h1);
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    chk("abort_nopulse", 128'(pulses), 128'h0);
    run_block("post_rst", K1, C1, P1, 1'b0);

    // repeated key (cache hit when enabled), then a new key
    run_block("same_key", K1, C1, P1, 1'b0);
    run_block("new_key", K2, C2, P2, 1'b0);

    // loopback against the encrypt model, valid_in toggled while busy
    for (int i = 0; i < 64; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      if (i % 8 == 7) rk = m_tag;
      run_block("loop", rk, enc(rk, rp), rp, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
